// File: rtl/pipe_datapath.sv
`timescale 1ns/1ps
// pipe_datapath: four-stage ID/EX/MEM/WB integer datapath with register file,
// word-addressed data memory, EX operand forwarding and a load-use interlock.
// Ports: clk; rst (async, active high); in_valid/in_ready instruction handshake;
// rs1, rs2, rd, ImmOp, RegWrite, ALUsrc, MemWrite, ResultSrc, ALUctrl decoded
// fields; Zero = MEM-stage result is zero; wb_valid = WB occupied; a0 = x10.
module pipe_datapath #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ALUctrl_WIDTH = 3,
    parameter int MEM_DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic                     RegWrite,
    input  logic                     ALUsrc,
    input  logic                     MemWrite,
    input  logic                     ResultSrc,
    input  logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic                     Zero,
    output logic                     wb_valid,
    output logic [DATA_WIDTH-1:0]    a0
);

    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int SHW  = $clog2(DATA_WIDTH);
    localparam int MAW  = $clog2(MEM_DEPTH);

    localparam logic [ALUctrl_WIDTH-1:0] OP_ADD = ALUctrl_WIDTH'(0);
    localparam logic [ALUctrl_WIDTH-1:0] OP_SUB = ALUctrl_WIDTH'(1);
    localparam logic [ALUctrl_WIDTH-1:0] OP_AND = ALUctrl_WIDTH'(2);
    localparam logic [ALUctrl_WIDTH-1:0] OP_OR  = ALUctrl_WIDTH'(3);
    localparam logic [ALUctrl_WIDTH-1:0] OP_XOR = ALUctrl_WIDTH'(4);
    localparam logic [ALUctrl_WIDTH-1:0] OP_SLT = ALUctrl_WIDTH'(5);
    localparam logic [ALUctrl_WIDTH-1:0] OP_SLL = ALUctrl_WIDTH'(6);
    localparam logic [ALUctrl_WIDTH-1:0] OP_SRL = ALUctrl_WIDTH'(7);

    typedef logic [DATA_WIDTH-1:0]    word_t;
    typedef logic [ADDRESS_WIDTH-1:0] ridx_t;

    typedef struct packed {
        logic                     valid;
        ridx_t                    rs1;
        ridx_t                    rs2;
        ridx_t                    rd;
        word_t                    imm;
        logic                     regwrite;
        logic                     alusrc;
        logic                     memwrite;
        logic                     resultsrc;
        logic [ALUctrl_WIDTH-1:0] aluctrl;
        word_t                    v1;
        word_t                    v2;
    } ex_t;

    typedef struct packed {
        logic  valid;
        ridx_t rd;
        logic  regwrite;
        logic  memwrite;
        logic  resultsrc;
        word_t alu;
        word_t wdata;
    } mem_t;

    typedef struct packed {
        logic  valid;
        ridx_t rd;
        logic  regwrite;
        word_t result;
    } wb_t;

    ex_t   ex_q, ex_d;
    mem_t  mem_q, mem_d;
    wb_t   wb_q, wb_d;

    word_t regs [NREG];
    word_t dmem [MEM_DEPTH];

    word_t          id_v1, id_v2;
    word_t          opa, opb, op2, alu;
    word_t          mem_rdata;
    logic [MAW-1:0] mem_addr;
    logic           ld_hazard, accept;
    logic           wb_we, mem_fw;

    assign wb_we  = wb_q.valid && wb_q.regwrite && (wb_q.rd != '0);
    assign mem_fw = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);

    // ID: register read with write-through of the value WB commits this edge.
    // regs[0] is never written, so x0 reads as zero.
    always_comb begin
        id_v1 = regs[rs1];
        id_v2 = regs[rs2];
        if (wb_we && (wb_q.rd == rs1)) id_v1 = wb_q.result;
        if (wb_we && (wb_q.rd == rs2)) id_v2 = wb_q.result;
    end

    // A load in EX has no data until MEM, so a consumer in ID waits one cycle.
    // rs2 only counts when it is actually used (register operand or store data).
    assign ld_hazard = in_valid && ex_q.valid && ex_q.resultsrc &&
                       ex_q.regwrite && (ex_q.rd != '0) &&
                       ((rs1 == ex_q.rd) ||
                        ((!ALUsrc || MemWrite) && (rs2 == ex_q.rd)));
    assign in_ready  = !ld_hazard;
    assign accept    = in_valid && in_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_d.valid = accept;
        if (accept) begin
            ex_d.rs1       = rs1;
            ex_d.rs2       = rs2;
            ex_d.rd        = rd;
            ex_d.imm       = ImmOp;
            ex_d.regwrite  = RegWrite;
            ex_d.alusrc    = ALUsrc;
            ex_d.memwrite  = MemWrite;
            ex_d.resultsrc = ResultSrc;
            ex_d.aluctrl   = ALUctrl;
            ex_d.v1        = id_v1;
            ex_d.v2        = id_v2;
        end
    end

    // EX forwarding: the younger producer (MEM) overrides the older one (WB).
    always_comb begin
        opa = ex_q.v1;
        opb = ex_q.v2;
        if (wb_we && (wb_q.rd == ex_q.rs1))   opa = wb_q.result;
        if (wb_we && (wb_q.rd == ex_q.rs2))   opb = wb_q.result;
        if (mem_fw && (mem_q.rd == ex_q.rs1)) opa = mem_q.alu;
        if (mem_fw && (mem_q.rd == ex_q.rs2)) opb = mem_q.alu;
    end

    assign op2 = ex_q.alusrc ? ex_q.imm : opb;

    always_comb begin
        alu = '0;
        unique case (ex_q.aluctrl)
            OP_ADD:  alu = opa + op2;
            OP_SUB:  alu = opa - op2;
            OP_AND:  alu = opa & op2;
            OP_OR:   alu = opa | op2;
            OP_XOR:  alu = opa ^ op2;
            OP_SLT:  alu = {{(DATA_WIDTH-1){1'b0}},
                            ($signed(opa) < $signed(op2))};
            OP_SLL:  alu = opa << op2[SHW-1:0];
            OP_SRL:  alu = opa >> op2[SHW-1:0];
            default: alu = '0;
        endcase
    end

    always_comb begin
        mem_d.valid     = ex_q.valid;
        mem_d.rd        = ex_q.rd;
        mem_d.regwrite  = ex_q.regwrite;
        mem_d.memwrite  = ex_q.memwrite;
        mem_d.resultsrc = ex_q.resultsrc;
        mem_d.alu       = alu;
        mem_d.wdata     = opb;
    end

    // Word index: byte offset and bits above the memory size are dropped.
    assign mem_addr  = mem_q.alu[MAW+1:2];
    assign mem_rdata = dmem[mem_addr];

    always_comb begin
        wb_d.valid    = mem_q.valid;
        wb_d.rd       = mem_q.rd;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.result   = mem_q.resultsrc ? mem_rdata : mem_q.alu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            Zero  <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            Zero  <= ex_q.valid && (alu == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_q.rd] <= wb_q.result;
        end
    end

    // Memory contents survive reset; reset clears mem_q.valid at once,
    // so an in-flight store can never complete afterwards.
    always_ff @(posedge clk) begin
        if (mem_q.valid && mem_q.memwrite) dmem[mem_addr] <= mem_q.wdata;
    end

    assign wb_valid = wb_q.valid;
    assign a0       = regs[10];

endmodule

// File: tb/tb_pipe_datapath.sv
`timescale 1ns/1ps
// tb_pipe_datapath: directed sequences, an ALU vector table and random
// instruction streams checked against an in-order instruction-level model.
module tb_pipe_datapath;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 3;
    localparam int MD = 256;
    localparam int HN = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic [DW-1:0] ImmOp = '0;
    logic          RegWrite = 1'b0, ALUsrc = 1'b0;
    logic          MemWrite = 1'b0, ResultSrc = 1'b0;
    logic [CW-1:0] ALUctrl = '0;
    logic          Zero, wb_valid;
    logic [DW-1:0] a0;

    pipe_datapath #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
        .ALUctrl_WIDTH(CW), .MEM_DEPTH(MD)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp),
        .RegWrite(RegWrite), .ALUsrc(ALUsrc), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .ALUctrl(ALUctrl),
        .Zero(Zero), .wb_valid(wb_valid), .a0(a0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        rw, src, mw, rsel;
        logic [2:0]  op;
    } instr_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic        z;
    } vec_t;

    // Architectural model: instructions execute in order at acceptance;
    // per-edge history gives the delayed visibility of each result.
    logic [31:0] xr [32];
    logic [31:0] dm [MD];
    bit          hv  [HN];
    bit          hz  [HN];
    logic [31:0] ha0 [HN];
    logic [4:0]  hld [HN];
    bit          hst [HN];
    logic [7:0]  hsi [HN];
    logic [31:0] hso [HN];

    int          ecnt = 0;
    logic [31:0] exp_a0 = '0;
    int          checks = 0;
    int          errors = 0;
    logic        obs_ready, obs_wb, obs_zero;
    logic [31:0] obs_a0;
    bit          last_acc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, exp, ecnt);
        end
    endtask

    function automatic bit model_ready();
        logic [4:0] l;
        if (rst || !in_valid || !hv[ecnt]) return 1'b1;
        l = hld[ecnt];
        if (l == 5'd0) return 1'b1;
        if (rs1 == l) return 1'b0;
        if ((!ALUsrc || MemWrite) && rs2 == l) return 1'b0;
        return 1'b1;
    endfunction

    task automatic execute();
        logic [31:0] a, b, o2, r, ld;
        logic [7:0]  idx;
        a  = xr[rs1];
        b  = xr[rs2];
        o2 = ALUsrc ? ImmOp : b;
        case (ALUctrl)
            3'd0:    r = a + o2;
            3'd1:    r = a - o2;
            3'd2:    r = a & o2;
            3'd3:    r = a | o2;
            3'd4:    r = a ^ o2;
            3'd5:    r = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
            3'd6:    r = a << o2[4:0];
            default: r = a >> o2[4:0];
        endcase
        idx = r[9:2];
        ld  = dm[idx];
        hst[ecnt] = MemWrite;
        hsi[ecnt] = idx;
        hso[ecnt] = ld;
        if (MemWrite) dm[idx] = b;
        if (RegWrite && rd != 5'd0) xr[rd] = ResultSrc ? ld : r;
        hv[ecnt]  = 1'b1;
        hz[ecnt]  = (r == 32'd0);
        ha0[ecnt] = xr[10];
        hld[ecnt] = (ResultSrc && RegWrite) ? rd : 5'd0;
    endtask

    task automatic step();
        bit rdy, acc, ewb, ez;
        @(negedge clk);
        rdy = model_ready();
        ewb = (ecnt >= 2) && hv[ecnt-2];
        ez  = (ecnt >= 1) && hv[ecnt-1] && hz[ecnt-1];
        obs_ready = in_ready;
        obs_a0    = a0;
        obs_wb    = wb_valid;
        obs_zero  = Zero;
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("a0", a0, exp_a0);
        check("wb_valid", 32'(wb_valid), 32'(ewb));
        check("zero", 32'(Zero), 32'(ez));
        acc = !rst && in_valid && rdy;
        @(posedge clk);
        ecnt++;
        if (ecnt >= HN) begin
            $display("FAIL history_overflow: edge %0d limit %0d", ecnt, HN);
            $fatal(1);
        end
        hv[ecnt] = 1'b0;
        if (acc) execute();
        if (ecnt >= 3 && hv[ecnt-3]) exp_a0 = ha0[ecnt-3];
        last_acc = acc;
        #1;
    endtask

    task automatic drive(input instr_t i);
        rs1 = i.rs1; rs2 = i.rs2; rd = i.rd; ImmOp = i.imm;
        RegWrite = i.rw; ALUsrc = i.src; MemWrite = i.mw;
        ResultSrc = i.rsel; ALUctrl = i.op;
    endtask

    task automatic issue(input instr_t i, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        drive(i);
        in_valid = 1'b1;
        for (int n = 0; n < 6 && !done; n++) begin
            step();
            if (last_acc) done = 1'b1;
            else stalls++;
        end
        check("accept", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            ImmOp = $urandom(); ALUctrl = 3'($urandom);
            RegWrite = 1'($urandom); ALUsrc = 1'($urandom);
            MemWrite = 1'($urandom); ResultSrc = 1'($urandom);
            step();
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int e = ecnt; e >= ecnt - 1 && e >= 0; e--)
            if (hv[e] && hst[e]) dm[hsi[e]] = hso[e];
        for (int e = ecnt - 2; e <= ecnt; e++)
            if (e >= 0) hv[e] = 1'b0;
        foreach (xr[k]) xr[k] = '0;
        exp_a0 = '0;
        #1;
        check("rst_a0_async", a0, 32'd0);
        check("rst_wb_async", 32'(wb_valid), 32'd0);
        check("rst_zero_async", 32'(Zero), 32'd0);
        check("rst_ready_async", 32'(in_ready), 32'd1);
        for (int k = 0; k < cycles; k++) step();
        rst = 1'b0;
    endtask

    function automatic instr_t mk(input logic [4:0] d, s1, s2,
                                  input logic [31:0] imm,
                                  input logic w, src, mw, rsel,
                                  input logic [2:0] op);
        instr_t i;
        i.rd = d; i.rs1 = s1; i.rs2 = s2; i.imm = imm;
        i.rw = w; i.src = src; i.mw = mw; i.rsel = rsel; i.op = op;
        return i;
    endfunction

    function automatic instr_t mk_ri(input logic [4:0] d, s1,
                                     input logic [31:0] imm,
                                     input logic [2:0] op);
        return mk(d, s1, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b0, op);
    endfunction

    function automatic instr_t mk_rr(input logic [4:0] d, s1, s2,
                                     input logic [2:0] op);
        return mk(d, s1, s2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, op);
    endfunction

    function automatic instr_t mk_st(input logic [4:0] s2, s1,
                                     input logic [31:0] imm);
        return mk(5'd0, s1, s2, imm, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    endfunction

    function automatic instr_t mk_ld(input logic [4:0] d, s1,
                                     input logic [31:0] imm);
        return mk(d, s1, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 5'd10 : 5'(r);
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.rs1  = pick_reg();
        i.rs2  = pick_reg();
        i.rd   = pick_reg();
        i.imm  = ($urandom_range(0, 1) == 1) ? $urandom()
                                              : 32'($urandom_range(0, 40));
        i.op   = 3'($urandom_range(0, 7));
        i.src  = 1'($urandom_range(0, 1));
        i.mw   = ($urandom_range(0, 99) < 15);
        i.rsel = ($urandom_range(0, 99) < 25);
        i.rw   = ($urandom_range(0, 99) < 85);
        return i;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt [14];
        int   st;

        vt[0]  = '{3'd0, 32'd5,        32'd7,        32'd12,       1'b0};
        vt[1]  = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vt[2]  = '{3'd1, 32'd4,        32'd4,        32'd0,        1'b1};
        vt[3]  = '{3'd1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vt[4]  = '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vt[5]  = '{3'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
        vt[6]  = '{3'd4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0};
        vt[7]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vt[8]  = '{3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vt[9]  = '{3'd5, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0};
        vt[10] = '{3'd6, 32'd1,        32'd31,       32'h80000000, 1'b0};
        vt[11] = '{3'd6, 32'd1,        32'd33,       32'd2,        1'b0};
        vt[12] = '{3'd7, 32'h80000000, 32'd31,       32'd1,        1'b0};
        vt[13] = '{3'd7, 32'hFFFFFFFF, 32'h24,       32'h0FFFFFFF, 1'b0};

        foreach (xr[k]) xr[k] = '0;
        foreach (dm[k]) dm[k] = '0;

        apply_reset(2);

        // single addi: WB occupied three edges later, a0 visible after four
        issue(mk_ri(5'd10, 5'd0, 32'd5, 3'd0), st);
        idle(2);
        check("req033_wb_early", 32'(obs_wb), 32'd0);
        idle(1);
        check("req033_wb", 32'(obs_wb), 32'd1);
        check("req033_a0_before", obs_a0, 32'd0);
        idle(1);
        check("req033_a0", obs_a0, 32'd5);

        // initialise every memory word through the pipeline
        for (int k = 0; k < MD; k++) begin
            issue(mk_ri(5'd3, 5'd0, $urandom(), 3'd0), st);
            issue(mk_st(5'd3, 5'd0, 32'(k * 4)), st);
        end

        // back-to-back dependent adds, no stall
        issue(mk_ri(5'd10, 5'd0, 32'd3, 3'd0), st);
        check("req034_stall0", 32'(st), 32'd0);
        issue(mk_rr(5'd10, 5'd10, 5'd10, 3'd0), st);
        check("req034_stall1", 32'(st), 32'd0);
        issue(mk_rr(5'd10, 5'd10, 5'd10, 3'd0), st);
        check("req034_stall2", 32'(st), 32'd0);
        idle(2);
        check("req034_a0_3", obs_a0, 32'd3);
        idle(1);
        check("req034_a0_6", obs_a0, 32'd6);
        idle(1);
        check("req034_a0_12", obs_a0, 32'd12);

        // store, load, dependent add: one interlock cycle
        issue(mk_ri(5'd5, 5'd0, 32'hDEAD, 3'd0), st);
        issue(mk_st(5'd5, 5'd0, 32'd8), st);
        issue(mk_ld(5'd10, 5'd0, 32'd8), st);
        check("req035_load_stall", 32'(st), 32'd0);
        issue(mk_rr(5'd10, 5'd10, 5'd0, 3'd0), st);
        check("req035_use_stall", 32'(st), 32'd1);
        idle(4);
        check("req035_a0", obs_a0, 32'h0000DEAD);

        // writes to x0 are dropped
        issue(mk_ri(5'd0, 5'd0, 32'd7, 3'd0), st);
        issue(mk_rr(5'd10, 5'd0, 5'd0, 3'd0), st);
        idle(4);
        check("req036_a0", obs_a0, 32'd0);

        // sub with immediate giving zero
        issue(mk_ri(5'd6, 5'd0, 32'd4, 3'd0), st);
        issue(mk_ri(5'd6, 5'd6, 32'd4, 3'd1), st);
        idle(2);
        check("req037_zero", 32'(obs_zero), 32'd1);

        // ALU vector table through forwarded register operands
        for (int v = 0; v < 14; v++) begin
            issue(mk_ri(5'd1, 5'd0, vt[v].a, 3'd0), st);
            issue(mk_ri(5'd2, 5'd0, vt[v].b, 3'd0), st);
            issue(mk_rr(5'd10, 5'd1, 5'd2, vt[v].op), st);
            idle(2);
            check($sformatf("vec%0d_zero", v), 32'(obs_zero), 32'(vt[v].z));
            idle(2);
            check($sformatf("vec%0d_a0", v), obs_a0, vt[v].res);
        end

        // random instruction stream
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 15) idle(1);
            else issue(rand_instr(), st);
        end
        idle(4);

        // reset with three instructions in flight
        issue(mk_ri(5'd7, 5'd0, 32'h1234, 3'd0), st);
        issue(mk_st(5'd7, 5'd0, 32'h40), st);
        issue(mk_ri(5'd10, 5'd0, 32'd9, 3'd0), st);
        idle(4);
        check("req038_a0_pre", obs_a0, 32'd9);
        issue(mk_ri(5'd10, 5'd0, 32'd1, 3'd0), st);
        issue(mk_ri(5'd7, 5'd0, 32'h5555, 3'd0), st);
        issue(mk_st(5'd7, 5'd0, 32'h40), st);
        apply_reset(2);
        idle(4);
        check("req038_no_late_write", obs_a0, 32'd0);
        check("req038_wb", 32'(obs_wb), 32'd0);
        issue(mk_ld(5'd10, 5'd0, 32'hFFFFFC43), st);
        idle(4);
        check("req038_mem_kept", obs_a0, 32'h00001234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and register width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register index width; 2**ADDRESS_WIDTH registers.
REQ-003 SHALL have parameter ALUctrl_WIDTH, default 3, ALU opcode width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, data memory depth in words; power of two.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  decoded instruction present on inputs.
REQ-008 SHALL have port in_ready  output  1  instruction accepted this edge when in_valid && in_ready.
REQ-009 SHALL have ports rs1, rs2, rd  input  ADDRESS_WIDTH each  source/destination register indices.
REQ-010 SHALL have port ImmOp  input  DATA_WIDTH  immediate operand.
REQ-011 SHALL have ports RegWrite, ALUsrc, MemWrite, ResultSrc  input  1 each  write-enable, immediate select, store, load select.
REQ-012 SHALL have port ALUctrl  input  ALUctrl_WIDTH  ALU operation.
REQ-013 SHALL have port Zero  output  1  registered ALU-result-equals-zero flag of the instruction in MEM stage.
REQ-014 SHALL have port wb_valid  output  1  an instruction is in WB stage this cycle.
REQ-015 SHALL have port a0  output  DATA_WIDTH  current contents of register 10.

Function
REQ-016 SHALL implement 4 stages: ID (accept + register read), EX (ALU), MEM (data memory), WB (register write), each with a valid bit.
REQ-017 SHALL write the register file at the edge ending WB; instruction accepted at edge k writes at edge k+3; a0 updates after edge k+3.
REQ-018 SHALL ignore writes to register 0 and always read register 0 as zero.
REQ-019 SHALL bypass a same-edge WB write into the ID register read (write-through).
REQ-020 SHALL forward EX operands with priority: MEM-stage ALU result, then WB result, then ID-captured value; match requires source valid, RegWrite=1, rd==rs, rd!=0.
REQ-021 SHALL drive in_ready=0 for exactly one cycle when EX holds a valid load (ResultSrc=1, RegWrite=1, rd!=0) and the input reads that rd via rs1, or via rs2 when ALUsrc=0 or MemWrite=1; a bubble enters EX.
REQ-022 SHALL drive in_ready=1 in all other cases; in_valid=0 inserts a bubble.
REQ-023 SHALL select ALU operand 2 as ImmOp when ALUsrc=1, else forwarded rs2 value.
REQ-024 SHALL implement ALUctrl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed set-less-than, 110 shift left logical, 111 shift right logical; shift amount = low $clog2(DATA_WIDTH) bits of operand 2; add/sub wrap modulo 2**DATA_WIDTH.
REQ-025 SHALL address data memory by word index ALUout[$clog2(MEM_DEPTH)+1:2], ignoring low 2 bits and higher bits (wrap modulo MEM_DEPTH).
REQ-026 SHALL write memory at the edge ending MEM when MemWrite=1 with forwarded rs2 value; load reads combinationally in MEM.
REQ-027 SHALL select WB result as loaded word when ResultSrc=1, else ALU result.
REQ-028 SHALL suppress register and memory writes of bubbles.
REQ-029 SHALL let a load followed by a store to same address return the old value (load precedes store in order).

Reset
REQ-030 SHALL on rst clear all stage valid bits, all registers to 0, Zero=0, wb_valid=0, a0=0 asynchronously.
REQ-031 SHALL drive in_ready=1 during and after reset; inputs ignored while rst=1.
REQ-032 SHALL not reset data memory contents; reset mid-operation discards in-flight instructions, no partial writes after rst asserts.

Verification
REQ-033 addi x10,x0,5 (ALUsrc=1,ImmOp=5,ALUctrl=000) at edge 1 -> a0=5 after edge 4, wb_valid high cycle 4.
REQ-034 back-to-back addi x10,x0,3; add x10,x10,x10; add x10,x10,x10 -> no stall, a0=3,6,12 on consecutive cycles.
REQ-035 store x5=0xDEAD to addr 8, then load x10 from addr 8, then add x10,x10,x0 -> in_ready low one cycle after load accepted, final a0=0xDEAD.
REQ-036 writes to x0 with value 7, then add x10,x0,x0 -> a0=0.
REQ-037 sub x6=4 minus imm 4 -> Zero=1 in MEM cycle; slt -1<1 -> 1; srl 0x80000000 by 31 -> 1.
REQ-038 rst asserted while three instructions in flight -> no register changes, a0=0, wb_valid=0 next cycle.
